regfile_sb: RTL
===============

# regfile_sb

Parametrised pipeline register file with an integrated scoreboard. It replaces the fixed 32x32, two-read-port register file in the decode stage. It adds:
- N read ports with same-cycle write-to-read bypass;
- a hard-wired zero register;
- asynchronous reset of all state;
- per-register busy tracking so decode can detect RAW/WAW hazards against in-flight writebacks.

Destination-register selection (rt/rd) is done in decode before this block, not inside it.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never busy
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k is at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, packed the same way as rd_addr
- rd_busy  out  NUM_RD  1 = the addressed register has a pending producer
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  request to reserve iss_addr for a new producer
- iss_addr  in  ADDR_W  destination being reserved
- iss_ok  out  1  reservation can be accepted this cycle
- flush  in  1  synchronous clear of all busy bits

## Operation
- Storage: 2**ADDR_W x DATA_W array plus a busy vector of 2**ADDR_W bits.
- Reset (rst_n=0, asynchronous): all registers = 0, all busy = 0. Outputs then read as rd_data=0, rd_busy=0, iss_ok=1.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. When ZERO_REG=1 and wr_addr=0, nothing changes.
- Read, port k: if BYPASS and wr_en and wr_addr==rd_addr_k (and rd_addr_k≠0 when ZERO_REG), rd_data_k = wr_data. Otherwise rd_data_k = reg[rd_addr_k]. When ZERO_REG=1, address 0 always reads 0.
- rd_busy_k = busy[rd_addr_k] AND NOT (BYPASS and wr_en and wr_addr==rd_addr_k). It is always 0 for address 0 when ZERO_REG=1.
- iss_ok = NOT busy[iss_addr] OR (wr_en and wr_addr==iss_addr). It is 1 for address 0 when ZERO_REG=1.
- Reservation handshake: the reservation is accepted on a rising edge when iss_en AND iss_ok AND NOT flush; then busy[iss_addr] <= 1.
  - If iss_en=1 and iss_ok=0, the request is ignored; decode must stall and hold the request.
  - Reserving address 0 with ZERO_REG=1 is accepted and has no effect.
- Simultaneous events on the same address:
  - Accepted issue and write to the same address in one cycle: set wins, busy = 1, and data is written.
  - flush=1: all busy bits <= 0 and a concurrent iss_en is dropped; a concurrent write still updates data.
- No read-port conflicts exist; all NUM_RD ports are independent.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- A write is visible from the array on the cycle after the edge; with BYPASS=1 it is also visible in the same cycle.
- A busy bit set by an accepted issue is seen on rd_busy/iss_ok from the next cycle.
- Reset is asynchronous assert and synchronous deassert (the deassert synchroniser is outside this block). Reset mid-operation discards all data and reservations immediately.
- Combinational path wr_en/wr_addr → rd_data/rd_busy/iss_ok is legal; integrators must budget for it.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W constants and the helper function that compares an address against the zero register.
- Sub-module regfile_scoreboard: busy vector, iss_ok, rd_busy, flush and set/clear priority. The top level holds the data array, bypass muxes and generate loop over NUM_RD.

## Test plan
- Reset: write reg 5 = 0xDEADBEEF, pulse rst_n low mid-cycle → rd_data for reg 5 = 0 immediately, all rd_busy=0, iss_ok=1.
- Bypass: wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr port 1 = 7 in the same cycle → rd_data1=0x12345678 and rd_busy1=0. With BYPASS=0 → old value.
- Zero register: write 0xFFFFFFFF to reg 0 and issue to reg 0 → reads 0, rd_busy=0, iss_ok=1.
- Scoreboard: issue reg 9 → next cycle rd_busy=1 and iss_ok=0 for 9; a repeated iss_en is ignored. Write reg 9 → same-cycle iss_ok=1, next cycle busy=0.
- Simultaneous events:
  - Issue and write reg 3 in one cycle → busy[3]=1 and data updated.
  - flush with issue reg 4 → busy[4]=0.
- NUM_RD=4, ADDR_W=6, DATA_W=64: random writes and reads on all 4 ports against a reference model over 10k cycles → no mismatch.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and address helpers for the decode-stage register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_ADDR_W = 32;

  // Callers widen their address to MAX_ADDR_W so one helper serves every ADDR_W.
  function automatic logic isZeroAddr(input logic [MAX_ADDR_W-1:0] addr,
                                      input logic                  zeroReg);
    return zeroReg && (addr == '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an in-flight producer and
// answers hazard queries for every read port and the issue port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  input  logic                     flush
);

  localparam int   DEPTH   = 1 << ADDR_W;
  localparam logic ZERO_EN = (ZERO_REG != 0);
  localparam logic BYP_EN  = (BYPASS != 0);

  logic [DEPTH-1:0] busy;
  logic             wrZero;
  logic             issZero;
  logic             issAccept;

  always_comb begin
    wrZero    = isZeroAddr(MAX_ADDR_W'(wr_addr), ZERO_EN);
    issZero   = isZeroAddr(MAX_ADDR_W'(iss_addr), ZERO_EN);
    // A writeback retiring the same register this cycle frees it for reuse.
    iss_ok    = issZero || !busy[iss_addr] || (wr_en && (wr_addr == iss_addr));
    issAccept = iss_en && iss_ok && !flush;
  end

  // Set is applied after clear so a same-cycle issue keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      if (wr_en && !wrZero)
        busy[wr_addr] <= 1'b0;
      if (issAccept && !issZero)
        busy[iss_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRdBusy
    logic [ADDR_W-1:0] rdAddr;
    logic              rdZero;
    logic              wrHit;
    assign rdAddr     = rd_addr[k*ADDR_W +: ADDR_W];
    assign rdZero     = isZeroAddr(MAX_ADDR_W'(rdAddr), ZERO_EN);
    assign wrHit      = BYP_EN && wr_en && (wr_addr == rdAddr);
    assign rd_busy[k] = !rdZero && busy[rdAddr] && !wrHit;
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with N bypassed read ports, optional hard-wired
// zero register and an integrated busy scoreboard for RAW/WAW detection.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ok,
  input  logic                     flush
);

  localparam int   DEPTH   = 1 << ADDR_W;
  localparam logic ZERO_EN = (ZERO_REG != 0);
  localparam logic BYP_EN  = (BYPASS != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wrZero;

  assign wrZero = isZeroAddr(MAX_ADDR_W'(wr_addr), ZERO_EN);

  // Data is cleared on reset too: a mid-run reset must discard all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en && !wrZero) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRdPort
    logic [ADDR_W-1:0] rdAddr;
    logic              rdZero;
    logic              wrHit;
    assign rdAddr = rd_addr[k*ADDR_W +: ADDR_W];
    assign rdZero = isZeroAddr(MAX_ADDR_W'(rdAddr), ZERO_EN);
    assign wrHit  = BYP_EN && wr_en && (wr_addr == rdAddr);

    always_comb begin
      rd_data[k*DATA_W +: DATA_W] = regs[rdAddr];
      if (rdZero)
        rd_data[k*DATA_W +: DATA_W] = '0;
      else if (wrHit)
        rd_data[k*DATA_W +: DATA_W] = wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) uScoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .iss_en  (iss_en),
    .iss_addr(iss_addr),
    .iss_ok  (iss_ok),
    .flush   (flush)
  );

endmodule
